// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: VGA reads take absolute priority with fixed latency,
// camera writes are buffered and drained on idle cycles. Optional stats: FB_ARB_STATS_EN.
module fb_port_arbiter #(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 16,
    parameter int WFIFO_DEPTH = 8,
    parameter int RD_LAT      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              frame_start,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant,
    output logic              late_err
`ifdef FB_ARB_STATS_EN
    ,
    output logic [31:0]       stat_rd_cnt,
    output logic [31:0]       stat_wr_cnt,
    output logic [7:0]        stat_stall_max
`endif
);

    localparam int PTR_W  = $clog2(WFIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PIPE_W = RD_LAT + 1;

    localparam logic [1:0] GNT_IDLE  = 2'd0;
    localparam logic [1:0] GNT_READ  = 2'd1;
    localparam logic [1:0] GNT_WRITE = 2'd2;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(WFIFO_DEPTH);

    logic [ADDR_W-1:0] fifo_addr_mem [WFIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_mem [WFIFO_DEPTH];

    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        grant_q, grant_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [PIPE_W-1:0] rd_pipe_q, rd_pipe_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              late_err_q, late_err_d;

    logic full, empty, push, pop;

    // Ready looks only at the registered count, so a pop never frees a slot in the same cycle.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign push  = wr_valid && !full;
    assign pop   = !rd_req && !empty;

    always_comb begin
        wptr_d      = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d      = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        count_d     = count_q;
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);

        grant_d     = GNT_IDLE;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (rd_req) begin
            grant_d    = GNT_READ;
            mem_en_d   = 1'b1;
            mem_addr_d = rd_addr;
        end else if (!empty) begin
            grant_d     = GNT_WRITE;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = fifo_addr_mem[rptr_q];
            mem_wdata_d = fifo_data_mem[rptr_q];
        end

        // Bit 0 marks the cycle the BRAM sees the read; bit RD_LAT marks mem_rdata valid.
        if (PIPE_W > 1)
            rd_pipe_d = {rd_pipe_q[PIPE_W-2:0], rd_req};
        else
            rd_pipe_d = rd_req;
        rd_valid_d = rd_pipe_q[RD_LAT];
        rd_data_d  = rd_pipe_q[RD_LAT] ? mem_rdata : rd_data_q;

        late_err_d = late_err_q | (frame_start && !empty);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_mem[wptr_q] <= wr_addr;
            fifo_data_mem[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            grant_q     <= GNT_IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_pipe_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            late_err_q  <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            grant_q     <= grant_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_pipe_q   <= rd_pipe_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            late_err_q  <= late_err_d;
        end
    end

    assign wr_ready  = !full;
    assign grant     = grant_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign late_err  = late_err_q;

`ifdef FB_ARB_STATS_EN
    logic [31:0] stat_rd_cnt_q, stat_rd_cnt_d;
    logic [31:0] stat_wr_cnt_q, stat_wr_cnt_d;
    logic [7:0]  stall_run_q, stall_run_d;
    logic [7:0]  stat_stall_max_q, stat_stall_max_d;

    always_comb begin
        stat_rd_cnt_d    = stat_rd_cnt_q;
        stat_wr_cnt_d    = stat_wr_cnt_q;
        stat_stall_max_d = stat_stall_max_q;
        if (grant_d == GNT_READ && stat_rd_cnt_q != '1)
            stat_rd_cnt_d = stat_rd_cnt_q + 32'd1;
        if (grant_d == GNT_WRITE && stat_wr_cnt_q != '1)
            stat_wr_cnt_d = stat_wr_cnt_q + 32'd1;
        stall_run_d = 8'd0;
        if (full && rd_req)
            stall_run_d = (stall_run_q == 8'hFF) ? stall_run_q : stall_run_q + 8'd1;
        if (stall_run_d > stat_stall_max_q)
            stat_stall_max_d = stall_run_d;
        if (frame_start) begin
            stat_rd_cnt_d    = '0;
            stat_wr_cnt_d    = '0;
            stall_run_d      = '0;
            stat_stall_max_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_rd_cnt_q    <= '0;
            stat_wr_cnt_q    <= '0;
            stall_run_q      <= '0;
            stat_stall_max_q <= '0;
        end else begin
            stat_rd_cnt_q    <= stat_rd_cnt_d;
            stat_wr_cnt_q    <= stat_wr_cnt_d;
            stall_run_q      <= stall_run_d;
            stat_stall_max_q <= stat_stall_max_d;
        end
    end

    assign stat_rd_cnt    = stat_rd_cnt_q;
    assign stat_wr_cnt    = stat_wr_cnt_q;
    assign stat_stall_max = stat_stall_max_q;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: BRAM model plus read/write scoreboards checked on the falling edge.
module tb_fb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req;
    logic [16:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        wr_valid;
    logic        wr_ready;
    logic [16:0] wr_addr;
    logic [15:0] wr_data;
    logic        frame_start;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic [1:0]  grant;
    logic        late_err;
`ifdef FB_ARB_STATS_EN
    logic [31:0] stat_rd_cnt;
    logic [31:0] stat_wr_cnt;
    logic [7:0]  stat_stall_max;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } rd_exp_t;
    typedef struct {
        logic [16:0] addr;
        logic [15:0] data;
    } wr_exp_t;

    rd_exp_t rdq[$];
    wr_exp_t wq[$];

    fb_port_arbiter dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_start(frame_start),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant(grant), .late_err(late_err)
`ifdef FB_ARB_STATS_EN
        , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_stall_max(stat_stall_max)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model, one-cycle read latency, preloaded with data = low address bits.
    logic [15:0] bram [0:1023];
    bit          loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) bram[i] <= 16'(i);
            loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) bram[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= bram[mem_addr[9:0]];
        end
    end

    always @(negedge clk) begin
        rd_exp_t re;
        wr_exp_t we;
        if (rdq.size() > 0 && rdq[0].cyc < cyc) begin
            n_total++;
            $display("FAIL rd_missing: no rd_valid at cycle %0d (now %0d)", rdq[0].cyc, cyc);
            void'(rdq.pop_front());
        end
        if (rd_valid === 1'b1) begin
            n_total++;
            if (rdq.size() == 0) begin
                $display("FAIL rd_unexpected: rd_valid at cycle %0d data %h, none expected", cyc, rd_data);
            end else begin
                re = rdq.pop_front();
                if (rd_data !== re.data || cyc !== re.cyc)
                    $display("FAIL rd_return: got data %h at cycle %0d, expected %h at cycle %0d",
                             rd_data, cyc, re.data, re.cyc);
                else
                    n_pass++;
            end
        end
        if (mem_en === 1'b1 && mem_we === 1'b1) begin
            n_total++;
            if (wq.size() == 0) begin
                $display("FAIL wr_unexpected: mem write addr %h data %h, none expected", mem_addr, mem_wdata);
            end else begin
                we = wq.pop_front();
                if (mem_addr !== we.addr || mem_wdata !== we.data)
                    $display("FAIL wr_order: got addr %h data %h, expected addr %h data %h",
                             mem_addr, mem_wdata, we.addr, we.data);
                else
                    n_pass++;
            end
        end
    end

    task automatic drive(input logic rd, input logic [16:0] ra, input logic wv,
                         input logic [16:0] wa, input logic [15:0] wd, input logic fs);
        @(posedge clk);
        #1;
        rd_req      = rd;
        rd_addr     = ra;
        wr_valid    = wv;
        wr_addr     = wa;
        wr_data     = wd;
        frame_start = fs;
        if (rd && !reset) rdq.push_back('{16'(ra[9:0]), cyc + 3});
        if (wv && wr_ready && !reset) wq.push_back('{wa, wd});
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((rdq.size() != 0 || wq.size() != 0) && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_total++;
        if (rdq.size() != 0 || wq.size() != 0)
            $display("FAIL drain_timeout: %0d reads and %0d writes still outstanding", rdq.size(), wq.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++; if (mem_en !== 1'b0) $display("FAIL rst_mem_en: got %b want 0", mem_en); else n_pass++;
        n_total++; if (rd_valid !== 1'b0) $display("FAIL rst_rd_valid: got %b want 0", rd_valid); else n_pass++;
        n_total++; if (wr_ready !== 1'b1) $display("FAIL rst_wr_ready: got %b want 1", wr_ready); else n_pass++;
        n_total++; if (grant !== 2'd0) $display("FAIL rst_grant: got %0d want 0", grant); else n_pass++;
        n_total++; if (late_err !== 1'b0) $display("FAIL rst_late_err: got %b want 0", late_err); else n_pass++;
        @(posedge clk);
        #1 reset = 1'b0;
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
        idle();
        @(negedge clk);
        n_total++; if (late_err !== 1'b0) $display("FAIL late_err_empty: got %b want 0", late_err); else n_pass++;
    endtask

    task automatic test_read_burst();
        for (int i = 0; i < 4; i++) drive(1'b1, 17'h10 + 17'(i), 1'b0, '0, '0, 1'b0);
        idle();
        wait_drain();
    endtask

    task automatic test_write_starve();
        int nwe = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 17'h20 + 17'(i), 1'b1, 17'h100 + 17'(i), 16'hA000 + 16'(i), 1'b0);
            @(negedge clk);
            n_total++;
            if (wq.size() != i + 1) $display("FAIL fill_accept: queued %0d want %0d", wq.size(), i + 1);
            else n_pass++;
            n_total++;
            if (mem_we !== 1'b0) $display("FAIL starve_we: got %b want 0", mem_we); else n_pass++;
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 17'h28 + 17'(i), 1'b0, '0, '0, 1'b0);
            @(negedge clk);
            n_total++; if (wr_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", wr_ready); else n_pass++;
            n_total++; if (mem_we !== 1'b0) $display("FAIL full_we: got %b want 0", mem_we); else n_pass++;
        end
        idle();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_we === 1'b1) nwe++;
        end
        n_total++; if (nwe != 8) $display("FAIL drain_count: got %0d write cycles want 8", nwe); else n_pass++;
        n_total++; if (wr_ready !== 1'b1) $display("FAIL drain_ready: got %b want 1", wr_ready); else n_pass++;
        wait_drain();
    endtask

    task automatic test_interleave();
        logic [3:0] pat = 4'b0101;
        logic [1:0] exp_g [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
        drive(1'b1, 17'h30, 1'b1, 17'h200, 16'hB000, 1'b0);
        drive(1'b1, 17'h31, 1'b1, 17'h201, 16'hB001, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k < 4) drive(pat[k], 17'h32 + 17'(k), 1'b0, '0, '0, 1'b0);
            else       idle();
            @(negedge clk);
            if (k > 0) begin
                n_total++;
                if (grant !== exp_g[k-1]) $display("FAIL interleave_grant[%0d]: got %0d want %0d", k - 1, grant, exp_g[k-1]);
                else n_pass++;
            end
        end
        idle();
        @(negedge clk);
        n_total++; if (grant !== 2'd0) $display("FAIL idle_grant: got %0d want 0", grant); else n_pass++;
        wait_drain();
    endtask

    task automatic test_late_err();
        drive(1'b1, 17'h38, 1'b1, 17'h300, 16'hC000, 1'b0);
        drive(1'b1, 17'h39, 1'b0, '0, '0, 1'b1);
        @(negedge clk);
        n_total++; if (late_err !== 1'b0) $display("FAIL late_err_early: got %b want 0", late_err); else n_pass++;
        idle();
        @(negedge clk);
        n_total++; if (late_err !== 1'b1) $display("FAIL late_err_set: got %b want 1", late_err); else n_pass++;
        repeat (5) idle();
        @(negedge clk);
        n_total++; if (late_err !== 1'b1) $display("FAIL late_err_sticky: got %b want 1", late_err); else n_pass++;
        wait_drain();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_total++; if (late_err !== 1'b0) $display("FAIL late_err_clear: got %b want 0", late_err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        drive(1'b1, 17'h3A, 1'b1, 17'h310, 16'hD000, 1'b0);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        rd_req   = 1'b0;
        wr_valid = 1'b0;
        rdq.delete();
        wq.delete();
        @(negedge clk);
        @(negedge clk);
        n_total++; if (mem_en !== 1'b0) $display("FAIL mid_rst_mem_en: got %b want 0", mem_en); else n_pass++;
        n_total++; if (rd_valid !== 1'b0) $display("FAIL mid_rst_rd_valid: got %b want 0", rd_valid); else n_pass++;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_en !== 1'b0 || rd_valid !== 1'b0) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL mid_rst_quiet: %0d active cycles want 0", bad); else n_pass++;
        n_total++; if (wr_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", wr_ready); else n_pass++;
    endtask

    initial begin
        reset       = 1'b1;
        rd_req      = 1'b0;
        rd_addr     = '0;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        frame_start = 1'b0;
        test_reset();
        test_read_burst();
        test_write_starve();
        test_interleave();
        test_late_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
